scoreboard_param: RTL
=====================

Name: scoreboard_param

Overview:
- Parametrised in-order-commit scoreboard between issue and commit; successor of the fixed 4-entry, 4-writeback-port scoreboard.
- Depth and writeback port count are generics.
- Adds operand forwarding, destination clobber tracking and a global flush.
- Each entry holds one scoreboard_entry; the entry index is the trans_id carried through the functional units.

Parameters:
NR_ENTRIES, 4, scoreboard depth; power of two, >=2
NR_WB_PORTS, 4, number of writeback ports
TRANS_ID_BITS, $clog2(NR_ENTRIES), trans_id width (derived, not overridden)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
flush_i  in  1  discard all entries
full_o  out  1  count==NR_ENTRIES
empty_o  out  1  count==0
decoded_instr_i  in  scoreboard_entry  instruction from decode
decoded_instr_valid_i  in  1  decode offers instruction
decoded_instr_ack_o  out  1  instruction consumed
issue_instr_o  out  scoreboard_entry  decoded_instr_i with trans_id=tail
issue_instr_valid_o  out  1  issue offer to functional units
issue_ack_i  in  1  functional unit accepts
wb_valid_i  in  NR_WB_PORTS  per-port writeback strobe
trans_id_i  in  NR_WB_PORTS x TRANS_ID_BITS  writeback target
wdata_i  in  NR_WB_PORTS x 64  writeback result
ex_i  in  NR_WB_PORTS x exception  writeback exception
commit_instr_o  out  scoreboard_entry  head entry
commit_valid_o  out  1  head occupied and finished
commit_ack_i  in  1  commit stage retires head
rs1_i, rs2_i  in  5  operand lookup addresses
rs1_o, rs2_o  out  64  forwarded operand
rs1_valid_o, rs2_valid_o  out  1  forwarded operand usable
rd_clobber_o  out  32  bit r set if any occupied entry targets rd==r

Behaviour:
- Storage: circular buffer with head (commit), tail (insert), count (0..NR_ENTRIES); each entry stores a scoreboard_entry plus an occupied bit.
- Reset (rst_i=1 at posedge): head=tail=count=0, all occupied/valid bits 0. Outputs then read: empty_o=1, full_o=0, commit_valid_o=0, rd_clobber_o=0, rs*_valid_o=0, issue_instr_valid_o=0.
- Issue:
  - issue_instr_valid_o = decoded_instr_valid_i & ~full_o & ~flush_i (combinational).
  - decoded_instr_ack_o = issue_instr_valid_o & issue_ack_i.
  - On ack: entry[tail] <= decoded_instr_i with trans_id=tail, occupied=1; tail++ mod NR_ENTRIES.
  - valid=1 at insert only if decoded_instr_i.ex.valid; otherwise valid=0.
- Full handling: full_o blocks issue even when a commit happens in the same cycle; there is no full bypass.
- Writeback:
  - For each port p with wb_valid_i[p]: if entry[trans_id_i[p]] is occupied, set result=wdata_i[p] and valid=1; if ex_i[p].valid, also set ex=ex_i[p].
  - Writeback to an unoccupied entry is ignored.
  - Two ports writing the same trans_id in one cycle is illegal (assertion); the highest-index port wins.
- Commit:
  - commit_valid_o = entry[head].occupied & entry[head].valid; commit_instr_o = entry[head].
  - commit_valid_o & commit_ack_i clears occupied and valid, then head++ mod NR_ENTRIES.
  - One commit per cycle.
  - Issue and commit in the same cycle leave count unchanged.
- Flush: flush_i has priority over issue, writeback and commit. It clears all occupied/valid bits and sets head=tail=count=0 next cycle. No ack is given that cycle.
- Forwarding (combinational, per rs):
  - Search occupied entries from tail-1 back to head for the youngest with rd==rs.
  - Hit with valid=1: rs_valid_o=1, rs_o=result.
  - Hit with valid=0, or no hit: rs_valid_o=0. On no hit the issue logic uses the regfile, gated by rd_clobber_o.
  - rs==0: rs_valid_o=0, rs_o=0, never a hit.
  - rs_o=0 whenever rs_valid_o=0.
- rd_clobber_o reflects registered state. Bit 0 is always 0. A bit stays set during the cycle its entry commits and clears the next cycle.

Optional Feature:
- SB_WB_BYPASS_EN defined: when the youngest hit is not yet valid and a wb port writes that trans_id in the current cycle, rs_valid_o=1 and rs_o=wdata_i of that port, in the same cycle as the writeback.
- Undefined: the forwarded value is available one cycle after the writeback.

Test Plan:
- Reset, then issue 4 instrs (rd=1..4) with issue_ack_i=1 -> trans_id 0..3, full_o=1, rd_clobber_o=0x1E, 5th decoded_instr_ack_o=0.
- Writeback trans_id 2 wdata=0xAA, then trans_id 0 -> commit_valid_o rises only after id 0 is written; commits retire in order 0,1(after wb),2; head wraps from 3 to 0.
- Full + commit_ack_i + new decode same cycle -> no ack that cycle; ack next cycle, tail wraps to 0, trans_id=0.
- Two entries rd=5 (older valid 0x11, younger pending); rs1_i=5 -> rs1_valid_o=0. With SB_WB_BYPASS_EN, younger wb 0x22 -> rs1_o=0x22 same cycle; without -> next cycle.
- Writeback with ex_i.valid cause=LD_ACCESS_FAULT -> commit_instr_o.ex.valid=1, cause=5; decode with ex.valid -> committable without wb.
- flush_i with 3 occupied and concurrent wb/issue/commit -> next cycle empty_o=1, rd_clobber_o=0, no ack or commit that cycle; rst_i mid-operation -> same empty state.

Source files
------------

// File: rtl/scoreboard_param.sv
// Parametrised in-order-commit scoreboard with operand forwarding, rd clobber tracking and flush.
// Optional macro SB_WB_BYPASS_EN: forward a same-cycle writeback to a pending operand lookup.
package scoreboard_pkg;
  typedef struct packed {
    logic [63:0] cause;
    logic [63:0] tval;
    logic        valid;
  } exception_t;

  localparam logic [63:0] LD_ACCESS_FAULT = 64'd5;

  // trans_id is sized for up to 256 entries; the scoreboard uses the low bits
  typedef struct packed {
    logic [63:0] pc;
    logic [7:0]  trans_id;
    logic [7:0]  op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [63:0] result;
    logic        valid;
    exception_t  ex;
  } scoreboard_entry_t;
endpackage

module sb_fwd #(
  parameter int NR_ENTRIES    = 4,
  parameter int NR_WB_PORTS   = 4,
  parameter int TRANS_ID_BITS = 2
) (
  input  logic [TRANS_ID_BITS-1:0]                  head,
  input  logic [NR_ENTRIES-1:0]                     occ,
  input  logic [NR_ENTRIES-1:0]                     ent_valid,
  input  logic [NR_ENTRIES-1:0][4:0]                ent_rd,
  input  logic [NR_ENTRIES-1:0][63:0]               ent_result,
  input  logic [4:0]                                rs,
  input  logic [NR_WB_PORTS-1:0]                    wb_valid,
  input  logic [NR_WB_PORTS-1:0][TRANS_ID_BITS-1:0] wb_id,
  input  logic [NR_WB_PORTS-1:0][63:0]              wb_data,
  output logic [63:0]                               rs_data,
  output logic                                      rs_valid
);
`ifdef SB_WB_BYPASS_EN
  localparam bit WB_BYPASS = 1'b1;
`else
  localparam bit WB_BYPASS = 1'b0;
`endif

  logic                     hit;
  logic [TRANS_ID_BITS-1:0] hit_idx;
  logic [TRANS_ID_BITS-1:0] idx;

  // Walk oldest to youngest so the last match is the youngest producer
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    idx     = '0;
    for (int i = 0; i < NR_ENTRIES; i++) begin
      idx = head + TRANS_ID_BITS'(i);
      if (occ[idx] && ent_rd[idx] == rs && rs != 5'd0) begin
        hit     = 1'b1;
        hit_idx = idx;
      end
    end
    rs_valid = 1'b0;
    rs_data  = '0;
    if (hit) begin
      if (ent_valid[hit_idx]) begin
        rs_valid = 1'b1;
        rs_data  = ent_result[hit_idx];
      end else if (WB_BYPASS) begin
        for (int p = 0; p < NR_WB_PORTS; p++)
          if (wb_valid[p] && wb_id[p] == hit_idx) begin
            rs_valid = 1'b1;
            rs_data  = wb_data[p];
          end
      end
    end
  end
endmodule

module scoreboard_param import scoreboard_pkg::*; #(
  parameter int  NR_ENTRIES    = 4,
  parameter int  NR_WB_PORTS   = 4,
  localparam int TRANS_ID_BITS = $clog2(NR_ENTRIES)
) (
  input  logic                                      clk_i,
  input  logic                                      rst_i,
  input  logic                                      flush_i,
  output logic                                      full_o,
  output logic                                      empty_o,
  input  scoreboard_entry_t                         decoded_instr_i,
  input  logic                                      decoded_instr_valid_i,
  output logic                                      decoded_instr_ack_o,
  output scoreboard_entry_t                         issue_instr_o,
  output logic                                      issue_instr_valid_o,
  input  logic                                      issue_ack_i,
  input  logic [NR_WB_PORTS-1:0]                    wb_valid_i,
  input  logic [NR_WB_PORTS-1:0][TRANS_ID_BITS-1:0] trans_id_i,
  input  logic [NR_WB_PORTS-1:0][63:0]              wdata_i,
  input  exception_t [NR_WB_PORTS-1:0]              ex_i,
  output scoreboard_entry_t                         commit_instr_o,
  output logic                                      commit_valid_o,
  input  logic                                      commit_ack_i,
  input  logic [4:0]                                rs1_i,
  input  logic [4:0]                                rs2_i,
  output logic [63:0]                               rs1_o,
  output logic [63:0]                               rs2_o,
  output logic                                      rs1_valid_o,
  output logic                                      rs2_valid_o,
  output logic [31:0]                               rd_clobber_o
);
  scoreboard_entry_t [NR_ENTRIES-1:0] mem_q;
  logic [NR_ENTRIES-1:0]              occ_q;
  logic [TRANS_ID_BITS-1:0]           head_q, tail_q;
  logic [TRANS_ID_BITS:0]             count_q;
  logic                               issue_fire, commit_fire, wb_dup;
  scoreboard_entry_t                  ins_entry;
  logic [NR_ENTRIES-1:0]              ent_valid;
  logic [NR_ENTRIES-1:0][4:0]         ent_rd;
  logic [NR_ENTRIES-1:0][63:0]        ent_result;
  logic [1:0][4:0]                    rs_addr;
  logic [1:0][63:0]                   rs_data;
  logic [1:0]                         rs_valid;
  logic                               unused_ok;

  assign unused_ok = ^{decoded_instr_i.trans_id};

  assign full_o              = (count_q == (TRANS_ID_BITS+1)'(NR_ENTRIES));
  assign empty_o             = (count_q == '0);
  assign issue_instr_valid_o = decoded_instr_valid_i & ~full_o & ~flush_i;
  assign decoded_instr_ack_o = issue_instr_valid_o & issue_ack_i;
  assign issue_fire          = decoded_instr_ack_o;
  assign commit_instr_o      = mem_q[head_q];
  assign commit_valid_o      = occ_q[head_q] & mem_q[head_q].valid;
  assign commit_fire         = commit_valid_o & commit_ack_i;

  always_comb begin
    issue_instr_o          = decoded_instr_i;
    issue_instr_o.trans_id = 8'(tail_q);
    ins_entry              = issue_instr_o;
    ins_entry.valid        = decoded_instr_i.ex.valid;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      occ_q   <= '0;
      for (int i = 0; i < NR_ENTRIES; i++) mem_q[i].valid <= 1'b0;
    end else begin
      for (int p = 0; p < NR_WB_PORTS; p++)
        if (wb_valid_i[p] && occ_q[trans_id_i[p]]) begin
          mem_q[trans_id_i[p]].result <= wdata_i[p];
          mem_q[trans_id_i[p]].valid  <= 1'b1;
          if (ex_i[p].valid) mem_q[trans_id_i[p]].ex <= ex_i[p];
        end
      // Commit clear must land after writeback so a retiring head ends up empty
      if (commit_fire) begin
        occ_q[head_q]       <= 1'b0;
        mem_q[head_q].valid <= 1'b0;
        head_q              <= head_q + TRANS_ID_BITS'(1);
      end
      if (issue_fire) begin
        mem_q[tail_q] <= ins_entry;
        occ_q[tail_q] <= 1'b1;
        tail_q        <= tail_q + TRANS_ID_BITS'(1);
      end
      case ({issue_fire, commit_fire})
        2'b10:   count_q <= count_q + (TRANS_ID_BITS+1)'(1);
        2'b01:   count_q <= count_q - (TRANS_ID_BITS+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_comb begin
    rd_clobber_o = '0;
    for (int i = 0; i < NR_ENTRIES; i++) begin
      ent_valid[i]  = mem_q[i].valid;
      ent_rd[i]     = mem_q[i].rd;
      ent_result[i] = mem_q[i].result;
      if (occ_q[i]) rd_clobber_o[mem_q[i].rd] = 1'b1;
    end
    rd_clobber_o[0] = 1'b0;
  end

  assign rs_addr = {rs2_i, rs1_i};

  for (genvar g = 0; g < 2; g++) begin : g_fwd
    sb_fwd #(
      .NR_ENTRIES(NR_ENTRIES), .NR_WB_PORTS(NR_WB_PORTS), .TRANS_ID_BITS(TRANS_ID_BITS)
    ) u_fwd (
      .head(head_q), .occ(occ_q), .ent_valid(ent_valid), .ent_rd(ent_rd),
      .ent_result(ent_result), .rs(rs_addr[g]), .wb_valid(wb_valid_i),
      .wb_id(trans_id_i), .wb_data(wdata_i), .rs_data(rs_data[g]), .rs_valid(rs_valid[g])
    );
  end

  assign rs1_o       = rs_data[0];
  assign rs2_o       = rs_data[1];
  assign rs1_valid_o = rs_valid[0];
  assign rs2_valid_o = rs_valid[1];

  // Two ports targeting one entry in a cycle is an upstream bug
  always_comb begin
    wb_dup = 1'b0;
    for (int p = 0; p < NR_WB_PORTS; p++)
      for (int q = p + 1; q < NR_WB_PORTS; q++)
        if (wb_valid_i[p] && wb_valid_i[q] && trans_id_i[p] == trans_id_i[q]) wb_dup = 1'b1;
  end

  a_wb_unique: assert property (@(posedge clk_i) disable iff (rst_i) !wb_dup);
endmodule
